// File: rtl/ack_event_queue.sv
// rtl/ack_event_queue.sv - FIFO of arbiter ack winners with sticky overflow and drop counter
module ack_event_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ack_event,
  input  logic [1:0]        winner_source_id,
  output logic              evt_valid,
  output logic [1:0]        evt_source_id,
  input  logic              evt_ready,
  output logic [ADDR_W:0]   evt_count,
  output logic              queue_full,
  output logic              overflow,
  output logic [7:0]        drop_cnt,
  input  logic              clr_overflow
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic [1:0]        mem [DEPTH];
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   count;
  logic              pop;
  logic              push_ok;
  logic              drop;

  // A pop frees a slot in the same cycle, so a full queue still accepts a push then.
  always_comb begin
    pop     = evt_valid & evt_ready;
    push_ok = ack_event & ((count < FULL_CNT) | pop);
    drop    = ack_event & ~push_ok;
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= winner_source_id;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      if (push_ok && !pop) begin
        count <= count + (ADDR_W + 1)'(1);
      end else if (pop && !push_ok) begin
        count <= count - (ADDR_W + 1)'(1);
      end
    end
  end

  // A drop in the same cycle as a clear wins and restarts the count at one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      drop_cnt <= 8'd0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clr_overflow) begin
        drop_cnt <= 8'd1;
      end else if (drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end else if (clr_overflow) begin
      overflow <= 1'b0;
      drop_cnt <= 8'd0;
    end
  end

  always_comb begin
    evt_valid     = (count != '0);
    evt_source_id = evt_valid ? mem[rd_ptr] : 2'b00;
    evt_count     = count;
    queue_full    = (count == FULL_CNT);
  end

endmodule

// File: tb/tb_ack_event_queue.sv
// tb/tb_ack_event_queue.sv - directed self-checking bench for ack_event_queue
module tb_ack_event_queue;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ack_event;
  logic [1:0] winner_source_id;
  logic       evt_valid;
  logic [1:0] evt_source_id;
  logic       evt_ready;
  logic [2:0] evt_count;
  logic       queue_full;
  logic       overflow;
  logic [7:0] drop_cnt;
  logic       clr_overflow;

  int pass_cnt  = 0;
  int total_cnt = 0;

  ack_event_queue #(.DEPTH(4), .ADDR_W(2)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ack_event        (ack_event),
    .winner_source_id (winner_source_id),
    .evt_valid        (evt_valid),
    .evt_source_id    (evt_source_id),
    .evt_ready        (evt_ready),
    .evt_count        (evt_count),
    .queue_full       (queue_full),
    .overflow         (overflow),
    .drop_cnt         (drop_cnt),
    .clr_overflow     (clr_overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(input logic [1:0] id);
    ack_event = 1'b1; winner_source_id = id; evt_ready = 1'b0;
    tick();
    ack_event = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ack_event = 1'b0; winner_source_id = 2'b00; evt_ready = 1'b0; clr_overflow = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    push_n(2'b01); push_n(2'b10); push_n(2'b11);
    total_cnt++; if (evt_count !== 3'd3) $display("FAIL reset_prefill_count got=%0d exp=3", evt_count); else pass_cnt++;
    rst_n = 1'b0; ack_event = 1'b1; winner_source_id = 2'b11;
    tick();
    ack_event = 1'b0;
    total_cnt++; if (evt_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", evt_valid); else pass_cnt++;
    total_cnt++; if (evt_source_id !== 2'b00) $display("FAIL reset_src got=%b exp=00", evt_source_id); else pass_cnt++;
    total_cnt++; if (evt_count !== 3'd0) $display("FAIL reset_count got=%0d exp=0", evt_count); else pass_cnt++;
    total_cnt++; if (queue_full !== 1'b0) $display("FAIL reset_full got=%b exp=0", queue_full); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b0) $display("FAIL reset_overflow got=%b exp=0", overflow); else pass_cnt++;
    total_cnt++; if (drop_cnt !== 8'd0) $display("FAIL reset_drop_cnt got=%0d exp=0", drop_cnt); else pass_cnt++;
    rst_n = 1'b1; evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    total_cnt++; if (evt_count !== 3'd0) $display("FAIL reset_ready_no_pop got=%0d exp=0", evt_count); else pass_cnt++;
    total_cnt++; if (evt_valid !== 1'b0) $display("FAIL reset_ready_valid got=%b exp=0", evt_valid); else pass_cnt++;
  endtask

  task automatic test_ordering();
    logic [1:0] exp_ids [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
    for (int i = 0; i < 4; i++) push_n(exp_ids[i]);
    total_cnt++; if (evt_count !== 3'd4) $display("FAIL order_count got=%0d exp=4", evt_count); else pass_cnt++;
    total_cnt++; if (queue_full !== 1'b1) $display("FAIL order_full got=%b exp=1", queue_full); else pass_cnt++;
    tick();
    total_cnt++; if (evt_source_id !== 2'b01) $display("FAIL order_hold got=%b exp=01", evt_source_id); else pass_cnt++;
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total_cnt++; if (evt_valid !== 1'b1 || evt_source_id !== exp_ids[i]) $display("FAIL order_head%0d got=%b/%b exp=1/%b", i, evt_valid, evt_source_id, exp_ids[i]); else pass_cnt++;
      tick();
    end
    evt_ready = 1'b0;
    total_cnt++; if (evt_valid !== 1'b0) $display("FAIL order_empty got=%b exp=0", evt_valid); else pass_cnt++;
  endtask

  task automatic test_overflow();
    logic [1:0] ids [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    for (int i = 0; i < 4; i++) push_n(ids[i]);
    push_n(2'b11); push_n(2'b10);
    total_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_flag got=%b exp=1", overflow); else pass_cnt++;
    total_cnt++; if (drop_cnt !== 8'd2) $display("FAIL ovf_drop_cnt got=%0d exp=2", drop_cnt); else pass_cnt++;
    total_cnt++; if (evt_count !== 3'd4) $display("FAIL ovf_count got=%0d exp=4", evt_count); else pass_cnt++;
    clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
    total_cnt++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) $display("FAIL ovf_clear got=%b/%0d exp=0/0", overflow, drop_cnt); else pass_cnt++;
    clr_overflow = 1'b1; push_n(2'b01); clr_overflow = 1'b0;
    total_cnt++; if (overflow !== 1'b1 || drop_cnt !== 8'd1) $display("FAIL ovf_clr_drop got=%b/%0d exp=1/1", overflow, drop_cnt); else pass_cnt++;
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total_cnt++; if (evt_source_id !== ids[i]) $display("FAIL ovf_content%0d got=%b exp=%b", i, evt_source_id, ids[i]); else pass_cnt++;
      tick();
    end
    evt_ready = 1'b0;
    clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
  endtask

  task automatic test_full_push_pop();
    logic [1:0] ids [4] = '{2'b00, 2'b01, 2'b10, 2'b00};
    logic [1:0] exp_ids [4] = '{2'b01, 2'b10, 2'b00, 2'b11};
    for (int i = 0; i < 4; i++) push_n(ids[i]);
    ack_event = 1'b1; winner_source_id = 2'b11; evt_ready = 1'b1;
    tick();
    ack_event = 1'b0;
    total_cnt++; if (evt_count !== 3'd4) $display("FAIL fpp_count got=%0d exp=4", evt_count); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) $display("FAIL fpp_no_drop got=%b/%0d exp=0/0", overflow, drop_cnt); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total_cnt++; if (evt_source_id !== exp_ids[i]) $display("FAIL fpp_head%0d got=%b exp=%b", i, evt_source_id, exp_ids[i]); else pass_cnt++;
      tick();
    end
    evt_ready = 1'b0;
    total_cnt++; if (evt_count !== 3'd0) $display("FAIL fpp_drained got=%0d exp=0", evt_count); else pass_cnt++;
  endtask

  task automatic test_empty_push_pop();
    ack_event = 1'b1; winner_source_id = 2'b10; evt_ready = 1'b1;
    tick();
    ack_event = 1'b0; evt_ready = 1'b0;
    total_cnt++; if (evt_valid !== 1'b1 || evt_source_id !== 2'b10) $display("FAIL epp_head got=%b/%b exp=1/10", evt_valid, evt_source_id); else pass_cnt++;
    total_cnt++; if (evt_count !== 3'd1) $display("FAIL epp_count got=%0d exp=1", evt_count); else pass_cnt++;
    evt_ready = 1'b1; tick(); evt_ready = 1'b0;
    total_cnt++; if (evt_valid !== 1'b0) $display("FAIL epp_pop got=%b exp=0", evt_valid); else pass_cnt++;
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 4; i++) push_n(2'(i));
    ack_event = 1'b1; winner_source_id = 2'b11;
    for (int i = 0; i < 300; i++) tick();
    ack_event = 1'b0;
    total_cnt++; if (drop_cnt !== 8'd255) $display("FAIL sat_drop_cnt got=%0d exp=255", drop_cnt); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b1 || evt_count !== 3'd4) $display("FAIL sat_state got=%b/%0d exp=1/4", overflow, evt_count); else pass_cnt++;
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    evt_ready = 1'b0;
    clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
    total_cnt++; if (evt_count !== 3'd0 || drop_cnt !== 8'd0) $display("FAIL sat_cleanup got=%0d/%0d exp=0/0", evt_count, drop_cnt); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [1:0] ids [10] = '{2'b01, 2'b00, 2'b11, 2'b10, 2'b01, 2'b00, 2'b11, 2'b10, 2'b01, 2'b00};
    push_n(ids[0]);
    evt_ready = 1'b1; ack_event = 1'b1;
    for (int i = 1; i < 10; i++) begin
      winner_source_id = ids[i];
      total_cnt++; if (evt_source_id !== ids[i-1] || evt_count !== 3'd1) $display("FAIL wrap_head%0d got=%b/%0d exp=%b/1", i, evt_source_id, evt_count, ids[i-1]); else pass_cnt++;
      tick();
    end
    ack_event = 1'b0;
    total_cnt++; if (evt_source_id !== ids[9]) $display("FAIL wrap_last got=%b exp=%b", evt_source_id, ids[9]); else pass_cnt++;
    tick();
    evt_ready = 1'b0;
    total_cnt++; if (evt_valid !== 1'b0) $display("FAIL wrap_empty got=%b exp=0", evt_valid); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_ordering();
    test_overflow();
    test_full_push_pop();
    test_empty_push_pop();
    test_saturation();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ack_event_queue.md
# ack_event_queue

Buffers completed acknowledgement grants from the ack-bus arbiter so the controller can consume them at its own pace. Each cycle with `ack_event` high, the block captures the 2-bit `winner_source_id` into a small FIFO. The controller pops entries through a valid/ready handshake. The block sits directly downstream of the arbiter, and its `queue_full` output is fed back to the request sources to gate new requests.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.
- `ADDR_W`, 2: log2(`DEPTH`); pointer width.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `ack_event`  in  1  arbiter event; each high cycle is one completed ack.
- `winner_source_id`  in  2  winner of that ack: 00 MEM, 01 SHA, 10 AES, 11 CTRL.
- `evt_valid`  out  1  head entry available.
- `evt_source_id`  out  2  source ID at head; 2'b00 when empty.
- `evt_ready`  in  1  controller accepts head; a pop occurs when `evt_valid & evt_ready`.
- `evt_count`  out  ADDR_W+1  number of occupied entries, 0..`DEPTH`.
- `queue_full`  out  1  `evt_count == DEPTH`.
- `overflow`  out  1  sticky; set when an event is dropped.
- `drop_cnt`  out  8  dropped-event count; saturates at 255.
- `clr_overflow`  in  1  clears `overflow` and `drop_cnt`.

## Operation
- Storage: `DEPTH` × 2-bit register array, plus read pointer, write pointer and occupancy counter (`ADDR_W`+1 bits). Pointers wrap modulo `DEPTH`.
- push = `ack_event`; pop = `evt_valid & evt_ready`.
- Accept rule: a push is accepted if `evt_count < DEPTH`, or if a pop occurs in the same cycle.
  - Full with simultaneous push and pop: head leaves, new entry written at the write pointer, count unchanged.
- Empty with simultaneous push: no bypass. The entry is written; `evt_valid` rises the next cycle.
- Drop: push while full with no pop. Entry discarded, pointers and count unchanged, `overflow` ← 1, `drop_cnt` ← min(`drop_cnt`+1, 255).
- `clr_overflow`: `overflow` ← 0 and `drop_cnt` ← 0. If a drop happens in the same cycle, the drop wins: `overflow` = 1, `drop_cnt` = 1.
- Count update: +1 on an accepted push without a pop; −1 on a pop without a push; unchanged otherwise.
- Pop without valid (`evt_ready` high while empty): no effect.
- `evt_source_id` = array[read pointer] when `evt_valid`, else 2'b00. It is held stable while `evt_valid & ~evt_ready`.
- Order: strict FIFO, preserving `ack_event` arrival order. Identical consecutive IDs are stored as separate entries.

## Timing
- Reset (`rst_n` low at a rising edge): pointers 0, count 0, `evt_valid` 0, `evt_source_id` 00, `evt_count` 0, `queue_full` 0, `overflow` 0, `drop_cnt` 0.
  - Reset mid-operation flushes all entries, with no pop or drop accounting.
  - `ack_event` during reset is ignored.
- Push latency: event sampled at edge N appears at head (if the queue was empty) with `evt_valid` = 1 after edge N, i.e. in cycle N+1.
- `evt_valid`, `evt_count` and `queue_full` are register-derived. No combinational path from `ack_event`, `winner_source_id` or `evt_ready` to any output.
- Throughput: one push and one pop per cycle sustained.
- `queue_full` rises the cycle after the `DEPTH`-th accepted push. Request sources must sample it and hold requests. An `ack_event` in the same cycle `queue_full` rises is still accepted only if a pop coincides; otherwise it is dropped.

## Test plan
- Reset: drive 3 events, assert `rst_n` = 0 for 1 cycle → all outputs at reset values; a later `evt_ready` pulse causes no pop.
- Ordering: push IDs 01, 10, 11, 00 on consecutive cycles with `evt_ready` = 0 → `evt_count` = 4, `queue_full` = 1. Then hold `evt_ready` = 1 → heads 01, 10, 11, 00 on successive cycles, then `evt_valid` = 0.
- Overflow: fill to 4, push 2 more with no pop → `overflow` = 1, `drop_cnt` = 2, contents unchanged.
  - Pulse `clr_overflow` → both 0.
  - Pulse `clr_overflow` together with a drop → `drop_cnt` = 1.
- Full push+pop: with 4 entries, push 11 while popping → count stays 4, no drop, 11 emerges after the 3 remaining entries.
- Empty push+pop: empty queue, `ack_event` = 1 with ID 10 and `evt_ready` = 1 → no pop that cycle; next cycle `evt_valid` = 1, `evt_source_id` = 10.
- Saturation: 300 drops while full → `drop_cnt` = 255; wrap check: 10 push/pop pairs with `DEPTH` = 4 → order preserved across pointer wrap.
